// File: rtl/eth_perf_snapshot_regs_pkg.sv
// Shared definitions for the Ethernet performance snapshot register block.
//   - ctr_idx_e      : counter order inside the packed counters bus (counter 0 in LSBs)
//   - ADDR_*         : word addresses of the read window
//   - snap_state_e   : snapshot FSM states
//   - ctr_delta      : modular 64-bit interval difference used by the delta build
// Optional feature macro: ETH_PERF_SNAPSHOT_DELTA_EN (delta-per-interval snapshots).
package eth_perf_snapshot_regs_pkg;

  localparam int NUM_COUNTERS_DEF = 5;

  typedef enum logic [2:0] {
    CTR_RX_FRAMES  = 3'd0,
    CTR_RX_CRC_ERR = 3'd1,
    CTR_RX_BYTES   = 3'd2,
    CTR_TX_FRAMES  = 3'd3,
    CTR_TX_BYTES   = 3'd4
  } ctr_idx_e;

  localparam logic [3:0] ADDR_CTR_BASE = 4'd0;
  localparam logic [3:0] ADDR_STATUS   = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DELTA   = 2'd2,
    ST_COMMIT  = 2'd3
  } snap_state_e;

  // Difference between two raw samples; modular so a counter wrap still
  // yields the true number of events in the interval.
  function automatic logic [63:0] ctr_delta(input logic [63:0] cur_raw,
                                            input logic [63:0] prev_raw);
    return cur_raw - prev_raw;
  endfunction

endpackage

// File: rtl/eth_perf_snapshot_lane.sv
// One counter lane of the snapshot block: staging register, visible register
// and (delta build only) the previous raw sample plus the interval subtractor.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   live         : live 64-bit counter value
//   capture_en   : latch live value into staging
//   delta_en     : (ETH_PERF_SNAPSHOT_DELTA_EN only) replace staging by interval delta
//   commit_en    : copy staging into the visible register
//   visible      : value presented to the read window
// Optional feature macro: ETH_PERF_SNAPSHOT_DELTA_EN.
module eth_perf_snapshot_lane
  import eth_perf_snapshot_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] live,
  input  logic        capture_en,
`ifdef ETH_PERF_SNAPSHOT_DELTA_EN
  input  logic        delta_en,
`endif
  input  logic        commit_en,
  output logic [63:0] visible
);

  logic [63:0] staging_r;
  logic [63:0] visible_r;

`ifdef ETH_PERF_SNAPSHOT_DELTA_EN
  logic [63:0] prev_raw_r;

  // Staging: raw capture, then overwritten by the interval delta one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_r <= 64'd0;
    end else if (capture_en) begin
      staging_r <= live;
    end else if (delta_en) begin
      staging_r <= ctr_delta(staging_r, prev_raw_r);
    end else begin
      staging_r <= staging_r;
    end
  end

  // Previous raw sample; starts at zero so the first interval is delta from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_raw_r <= 64'd0;
    end else if (delta_en) begin
      prev_raw_r <= staging_r;
    end else begin
      prev_raw_r <= prev_raw_r;
    end
  end
`else
  // Staging: raw capture of the live counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_r <= 64'd0;
    end else if (capture_en) begin
      staging_r <= live;
    end else begin
      staging_r <= staging_r;
    end
  end
`endif

  // Visible bank: only changes on the edge that ends the commit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      visible_r <= 64'd0;
    end else if (commit_en) begin
      visible_r <= staging_r;
    end else begin
      visible_r <= visible_r;
    end
  end

  assign visible = visible_r;

endmodule

// File: rtl/eth_perf_snapshot_regs.sv
// Atomic snapshot of the MAC performance counters exposed as a 32-bit
// read-only register window. All lanes capture and commit together, so any
// low/high word pair read back belongs to the same snapshot.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   counters     : NUM_COUNTERS x 64-bit live counters, counter 0 in LSBs
//   snap_req     : single-cycle capture request (accepted only when idle)
//   snap_busy    : capture in progress
//   snap_done    : one-cycle pulse during the commit cycle
//   rd_en, rd_addr : register read strobe and word address
//   rd_valid, rd_data : read response one cycle after rd_en
// Address map: 0..9 counters (low word at 2k, high at 2k+1),
//   10 status {overrun, 14'b0, delta_mode, seq[15:0]}, 11..15 read as 0.
// Optional feature macro: ETH_PERF_SNAPSHOT_DELTA_EN (visible bank holds
//   per-interval deltas, adds a DELTA state between CAPTURE and COMMIT).
module eth_perf_snapshot_regs
  import eth_perf_snapshot_regs_pkg::*;
#(
  parameter int SEQ_WIDTH    = 16,
  parameter int NUM_COUNTERS = NUM_COUNTERS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [64*NUM_COUNTERS-1:0] counters,
  input  logic                       snap_req,
  output logic                       snap_busy,
  output logic                       snap_done,
  input  logic                       rd_en,
  input  logic [3:0]                 rd_addr,
  output logic                       rd_valid,
  output logic [31:0]                rd_data
);

`ifdef ETH_PERF_SNAPSHOT_DELTA_EN
  localparam logic DELTA_MODE = 1'b1;
`else
  localparam logic DELTA_MODE = 1'b0;
`endif

  snap_state_e          state_r;
  logic                 busy_r;
  logic                 done_r;
  logic [SEQ_WIDTH-1:0] seq_r;
  logic                 overrun_r;
  logic                 rd_valid_r;
  logic [31:0]          rd_data_r;

  logic                 capture_en_s;
  logic                 commit_en_s;
  logic [63:0]          vis_s [NUM_COUNTERS];
  logic [31:0]          status_s;
  logic [3:0]           ctr_off_s;
  logic [31:0]          rd_word_s;

  assign capture_en_s = (state_r == ST_CAPTURE);
  assign commit_en_s  = (state_r == ST_COMMIT);

`ifdef ETH_PERF_SNAPSHOT_DELTA_EN
  logic delta_en_s;
  assign delta_en_s = (state_r == ST_DELTA);
`endif

  for (genvar k = 0; k < NUM_COUNTERS; k++) begin : g_lane
    eth_perf_snapshot_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .live       (counters[64*k +: 64]),
      .capture_en (capture_en_s),
`ifdef ETH_PERF_SNAPSHOT_DELTA_EN
      .delta_en   (delta_en_s),
`endif
      .commit_en  (commit_en_s),
      .visible    (vis_s[k])
    );
  end

  // Snapshot FSM; busy/done are registered alongside the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      seq_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (snap_req) begin
            state_r <= ST_CAPTURE;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
          done_r <= 1'b0;
        end
        ST_CAPTURE: begin
`ifdef ETH_PERF_SNAPSHOT_DELTA_EN
          state_r <= ST_DELTA;
          done_r  <= 1'b0;
`else
          state_r <= ST_COMMIT;
          done_r  <= 1'b1;
`endif
          busy_r <= 1'b1;
        end
        ST_DELTA: begin
          state_r <= ST_COMMIT;
          busy_r  <= 1'b1;
          done_r  <= 1'b1;
        end
        ST_COMMIT: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          seq_r   <= seq_r + SEQ_WIDTH'(1);
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a request outside IDLE sets it, a status read clears it;
  // set takes priority when both happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (snap_req && (state_r != ST_IDLE)) begin
      overrun_r <= 1'b1;
    end else if (rd_en && (rd_addr == ADDR_STATUS)) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign status_s = {overrun_r, 14'd0, DELTA_MODE, 16'(seq_r)};

  // Read mux over the visible bank and status word.
  always_comb begin
    ctr_off_s = rd_addr - ADDR_CTR_BASE;
    rd_word_s = 32'd0;
    if (rd_addr == ADDR_STATUS) begin
      rd_word_s = status_s;
    end else if (ctr_off_s < 4'(2 * NUM_COUNTERS)) begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        if (ctr_off_s[3:1] == 3'(k)) begin
          rd_word_s = ctr_off_s[0] ? vis_s[k][63:32] : vis_s[k][31:0];
        end else begin
          rd_word_s = rd_word_s;
        end
      end
    end else begin
      rd_word_s = 32'd0;
    end
  end

  // Read response register; data holds its last value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= 32'd0;
    end else if (rd_en) begin
      rd_valid_r <= 1'b1;
      rd_data_r  <= rd_word_s;
    end else begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= rd_data_r;
    end
  end

  assign snap_busy = busy_r;
  assign snap_done = done_r;
  assign rd_valid  = rd_valid_r;
  assign rd_data   = rd_data_r;

endmodule

// File: tb/tb_eth_perf_snapshot_regs.sv
// Self-checking bench for eth_perf_snapshot_regs. Read responses are checked
// against a scoreboard queue filled when each read is issued; expected words
// come from a small snapshot model kept by the bench.
module tb_eth_perf_snapshot_regs;

  localparam int NC       = 5;
  localparam int TB_SEQ_W = 4;
`ifdef ETH_PERF_SNAPSHOT_DELTA_EN
  localparam logic DM  = 1'b1;
  localparam int   LAT = 3;
`else
  localparam logic DM  = 1'b0;
  localparam int   LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [64*NC-1:0]  counters;
  logic              snap_req = 1'b0;
  logic              snap_busy;
  logic              snap_done;
  logic              rd_en = 1'b0;
  logic [3:0]        rd_addr = 4'd0;
  logic              rd_valid;
  logic [31:0]       rd_data;

  logic [63:0] ctr     [NC];
  logic [63:0] ctr_nxt [NC];
  logic [63:0] m_vis   [NC];
  logic [63:0] m_prev  [NC];
  logic [TB_SEQ_W-1:0] m_seq;
  logic        m_ovr;
  int          m_done;
  int          done_seen;
  int          n_vec;
  int          n_err;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  eth_perf_snapshot_regs #(.SEQ_WIDTH(TB_SEQ_W), .NUM_COUNTERS(NC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .counters  (counters),
    .snap_req  (snap_req),
    .snap_busy (snap_busy),
    .snap_done (snap_done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NC; k++) counters[64*k +: 64] = ctr[k];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid read response must match the oldest issued read.
  always @(negedge clk) begin
    rd_exp_t e;
    if (snap_done === 1'b1) done_seen++;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("rd_addr%0d", e.addr), {32'd0, rd_data}, {32'd0, e.data});
      end
    end
  end

  function automatic logic [31:0] exp_word(input logic [3:0] a);
    logic [63:0] v;
    if (a < 4'd10) begin
      v = m_vis[a[3:1]];
      return a[0] ? v[63:32] : v[31:0];
    end else if (a == 4'd10) begin
      return {m_ovr, 14'd0, DM, 16'(m_seq)};
    end else begin
      return 32'd0;
    end
  endfunction

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    rd_exp_t x;
    @(negedge clk);
    rd_en = 1'b1;
    rd_addr = a;
    x.addr = a;
    x.data = e;
    exp_q.push_back(x);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic rd_m(input logic [3:0] a);
    rd(a, exp_word(a));
    if (a == 4'd10) m_ovr = 1'b0;
  endtask

  task automatic set_ctr(input int k, input logic [63:0] v);
    ctr[k] = v;
    ctr_nxt[k] = v;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_vis[k] = 64'd0;
      m_prev[k] = 64'd0;
    end
    m_seq = '0;
    m_ovr = 1'b0;
  endtask

  // One snapshot: snap_req held for 'hold' cycles, live counters switch to
  // ctr_nxt right after the capture edge, optional read of addr 0 in COMMIT.
  task automatic snap(input int hold, input logic rd_commit);
    logic [63:0] cap [NC];
    rd_exp_t x;
    @(negedge clk);
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = (hold > 1) ? 1'b1 : 1'b0;
    chk("busy_capture", {63'd0, snap_busy}, 64'd1);
    chk("done_early", {63'd0, snap_done}, 64'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < NC; k++) begin
      cap[k] = ctr[k];
      ctr[k] = ctr_nxt[k];
    end
    snap_req = 1'b0;
    if (hold > 1) m_ovr = 1'b1;
    @(negedge clk);
    for (int i = 2; i < LAT; i++) begin
      chk("done_early_delta", {63'd0, snap_done}, 64'd0);
      @(negedge clk);
    end
    chk("snap_done", {63'd0, snap_done}, 64'd1);
    chk("busy_commit", {63'd0, snap_busy}, 64'd1);
    if (rd_commit) begin
      rd_en = 1'b1;
      rd_addr = 4'd0;
      x.addr = 4'd0;
      x.data = exp_word(4'd0);
      exp_q.push_back(x);
    end
    for (int k = 0; k < NC; k++) begin
      if (DM) begin
        m_vis[k] = cap[k] - m_prev[k];
        m_prev[k] = cap[k];
      end else begin
        m_vis[k] = cap[k];
      end
    end
    m_seq = m_seq + 1'b1;
    m_done++;
    @(negedge clk);
    rd_en = 1'b0;
    chk("done_pulse_end", {63'd0, snap_done}, 64'd0);
    chk("busy_end", {63'd0, snap_busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwrap;
    n_vec = 0;
    n_err = 0;
    m_done = 0;
    done_seen = 0;
    for (int k = 0; k < NC; k++) set_ctr(k, 64'd0);
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, snap_busy}, 64'd0);
    chk("rst_done", {63'd0, snap_done}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
    rst_n = 1'b1;
    for (int a = 0; a <= 10; a++) rd_m(4'(a));
    rd(4'd10, {15'd0, DM, 16'd0});

    // Atomic capture while rx_bytes moves across the 32-bit boundary
    set_ctr(0, 64'd11);
    set_ctr(1, 64'h0000_0000_0000_0003);
    set_ctr(2, 64'h0000_0001_FFFF_FFF0);
    ctr_nxt[2] = 64'h0000_0002_0000_0010;
    set_ctr(3, 64'h1234_5678_9ABC_DEF0);
    set_ctr(4, 64'h8000_0000_0000_0001);
    snap(1, 1'b0);
    rd(4'd4, 32'hFFFF_FFF0);
    rd(4'd5, 32'h0000_0001);
    for (int a = 0; a < 16; a++) rd_m(4'(a));

    // Back-to-back requests: one snapshot, overrun set then cleared by status read
    snap(2, 1'b0);
    @(negedge clk);
    chk("single_done", {63'd0, snap_done}, 64'd0);
    rd(4'd10, {1'b1, 14'd0, DM, 16'd2});
    m_ovr = 1'b0;
    rd(4'd10, {1'b0, 14'd0, DM, 16'd2});
    rd_m(4'd4);
    rd_m(4'd5);

    // Read in the COMMIT cycle returns the pre-commit value
    set_ctr(0, 64'd5);
    snap(1, 1'b0);
    rd_m(4'd0);
    set_ctr(0, 64'd9);
    snap(1, 1'b1);
    rd_m(4'd0);
    rd_m(4'd1);

`ifdef ETH_PERF_SNAPSHOT_DELTA_EN
    // Interval deltas, including a 64-bit wrap
    set_ctr(3, 64'd100);
    snap(1, 1'b0);
    set_ctr(3, 64'd250);
    snap(1, 1'b0);
    rd(4'd6, 32'd150);
    rd(4'd7, 32'd0);
    set_ctr(3, 64'hFFFF_FFFF_FFFF_FFFE);
    snap(1, 1'b0);
    set_ctr(3, 64'h3);
    snap(1, 1'b0);
    rd(4'd6, 32'd5);
    rd(4'd7, 32'd0);
`endif

    // Sequence counter wrap
    nwrap = (1 << TB_SEQ_W) - int'(m_seq);
    for (int i = 0; i < nwrap; i++) begin
      set_ctr(1, 64'(i + 7));
      snap(1, 1'b0);
    end
    rd(4'd10, {15'd0, DM, 16'd0});
    rd_m(4'd2);
    rd_m(4'd3);

    // Reset asserted during CAPTURE: no done pulse, banks zeroed
    @(negedge clk);
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    chk("busy_pre_rst", {63'd0, snap_busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("busy_in_rst", {63'd0, snap_busy}, 64'd0);
    chk("done_in_rst", {63'd0, snap_done}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    chk("done_after_rst", {63'd0, snap_done}, 64'd0);
    for (int a = 0; a < 16; a++) rd_m(4'(a));

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(done_seen), 64'(m_done));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
